// File: rtl/arm_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// arm_multicycle_ctrl
//   Multicycle sequencer for an ARM datapath that shares one ALU and one memory
//   port across the cycles of an instruction. It walks each instruction through
//   FETCH / DECODE / EXECUTE / MEM / WB, evaluates the ARM condition field
//   against NZCV in DECODE, and stalls FETCH/MEMRD/MEMWR on mem_ready.
//
//   Optional build macro: ARM_CTRL_PERF_EN adds instr_cnt / stall_cnt outputs.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   op, funct, cond     instruction register fields [27:26], [25:20], [31:28]
//   NZCV                current flag register {N,Z,C,V}
//   mem_ready           memory completes the access this cycle
//   IRWrite, PCWrite    instruction register / PC load enables
//   AdrSrc              memory address select (0=PC, 1=ALUOut)
//   ALUSrcA, ALUSrcB    ALU operand selects
//   ALUOp               ALU function
//   ImmSrc              immediate extension format
//   ResultSrc           result bus select
//   RegWrite, MemWrite  register file / memory write enables
//   FlagWrite           NZCV register write enable
//   illegal             one-cycle pulse when op==2'b11 is decoded
//   state               current state (debug)
//   instr_cnt           retired instructions (ARM_CTRL_PERF_EN only)
//   stall_cnt           memory wait cycles  (ARM_CTRL_PERF_EN only)
// -----------------------------------------------------------------------------
module arm_multicycle_ctrl #(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         op,
    input  logic [5:0]         funct,
    input  logic [3:0]         cond,
    input  logic [3:0]         NZCV,
    input  logic               mem_ready,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [3:0]         ALUOp,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         ResultSrc,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               FlagWrite,
    output logic               illegal,
    output logic [STATE_W-1:0] state
`ifdef ARM_CTRL_PERF_EN
    ,
    output logic [31:0]        instr_cnt,
    output logic [31:0]        stall_cnt
`endif
);

    typedef enum logic [STATE_W-1:0] {
        FETCH,
        DECODE,
        EXECR,
        EXECI,
        ALUWB,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        BRANCH
    } state_e;

    state_e state_q, state_d;

    logic n_f, z_f, c_f, v_f;
    logic cond_ex;

    assign {n_f, z_f, c_f, v_f} = NZCV;

    // Full ARM condition set; 4'b1111 never executes.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = !z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = !c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = !n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = !v_f;
            4'b1000: cond_ex = c_f && !z_f;
            4'b1001: cond_ex = !c_f || z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = !z_f && (n_f == v_f);
            4'b1101: cond_ex = z_f || (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // Next state and per-state datapath controls. Outputs depend on the
    // current state plus op/funct (and mem_ready in FETCH), so they are not
    // registered; reset forces every control low in the reset cycle itself.
    always_comb begin
        state_d   = FETCH;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 4'b0000;
        ImmSrc    = 2'b00;
        ResultSrc = 2'b00;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        FlagWrite = 1'b0;
        illegal   = 1'b0;

        case (state_q)
            FETCH: begin
                AdrSrc    = 1'b0;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ALUOp     = 4'b0100;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                if (op == 2'b11) begin
                    illegal = 1'b1;
                    state_d = FETCH;
                end else if (!cond_ex) begin
                    state_d = FETCH;
                end else begin
                    case (op)
                        2'b00:   state_d = funct[5] ? EXECI : EXECR;
                        2'b01:   state_d = MEMADR;
                        default: state_d = BRANCH;
                    endcase
                end
            end
            EXECR, EXECI: begin
                ALUSrcA = 1'b0;
                ALUSrcB = (state_q == EXECI) ? 2'b01 : 2'b00;
                ImmSrc  = 2'b00;
                ALUOp   = funct[4:1];
                state_d = ALUWB;
            end
            ALUWB: begin
                ResultSrc = 2'b00;
                FlagWrite = funct[0];
                RegWrite  = (funct[4:1] != 4'b1010);
                state_d   = FETCH;
            end
            MEMADR: begin
                ALUSrcA = 1'b0;
                ALUSrcB = 2'b01;
                ImmSrc  = 2'b01;
                ALUOp   = funct[3] ? 4'b0100 : 4'b0010;
                state_d = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                state_d = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                state_d   = FETCH;
            end
            MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                state_d  = mem_ready ? FETCH : MEMWR;
            end
            BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b01;
                ImmSrc    = 2'b10;
                ALUOp     = 4'b0100;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
                state_d   = FETCH;
            end
            default: state_d = FETCH;
        endcase

        if (reset) begin
            state_d   = FETCH;
            IRWrite   = 1'b0;
            PCWrite   = 1'b0;
            AdrSrc    = 1'b0;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 2'b00;
            ALUOp     = 4'b0000;
            ImmSrc    = 2'b00;
            ResultSrc = 2'b00;
            RegWrite  = 1'b0;
            MemWrite  = 1'b0;
            FlagWrite = 1'b0;
            illegal   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

`ifdef ARM_CTRL_PERF_EN
    logic        last_cyc;
    logic        wait_cyc;
    logic [31:0] instr_cnt_q;
    logic [31:0] stall_cnt_q;

    // last_cyc marks the final cycle of an instruction, including the
    // DECODE exit of cond-failed and illegal instructions.
    always_comb begin
        last_cyc = 1'b0;
        wait_cyc = 1'b0;
        case (state_q)
            FETCH:  wait_cyc = !mem_ready;
            DECODE: last_cyc = (op == 2'b11) || !cond_ex;
            ALUWB:  last_cyc = 1'b1;
            MEMWB:  last_cyc = 1'b1;
            BRANCH: last_cyc = 1'b1;
            MEMRD:  wait_cyc = !mem_ready;
            MEMWR: begin
                wait_cyc = !mem_ready;
                last_cyc = mem_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (last_cyc) instr_cnt_q <= instr_cnt_q + 32'd1;
            if (wait_cyc) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign instr_cnt = instr_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_arm_multicycle_ctrl
//   Drives directed and random instructions into arm_multicycle_ctrl. For each
//   instruction a per-cycle plan of expected controls is built from the
//   instruction class (DP / LDR / STR / B / skipped / illegal); every cycle the
//   DUT controls are compared against the plan.
// -----------------------------------------------------------------------------
module tb_arm_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cond;
    logic [3:0] NZCV;
    logic       mem_ready;
    logic       IRWrite, PCWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [3:0] ALUOp;
    logic [1:0] ImmSrc, ResultSrc;
    logic       RegWrite, MemWrite, FlagWrite, illegal;
    logic [3:0] state;
`ifdef ARM_CTRL_PERF_EN
    logic [31:0] instr_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    arm_multicycle_ctrl #(.STATE_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .funct     (funct),
        .cond      (cond),
        .NZCV      (NZCV),
        .mem_ready (mem_ready),
        .IRWrite   (IRWrite),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .ImmSrc    (ImmSrc),
        .ResultSrc (ResultSrc),
        .RegWrite  (RegWrite),
        .MemWrite  (MemWrite),
        .FlagWrite (FlagWrite),
        .illegal   (illegal),
        .state     (state)
`ifdef ARM_CTRL_PERF_EN
        ,
        .instr_cnt (instr_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    typedef struct packed {
        logic       ir;
        logic       pcw;
        logic       adr;
        logic       srca;
        logic [1:0] srcb;
        logic [3:0] aluop;
        logic [1:0] imm;
        logic [1:0] res;
        logic       rw;
        logic       mw;
        logic       fw;
        logic       ill;
    } ctl_t;

    // One plan entry per architectural step; "waits" steps repeat while
    // mem_ready is low (with IRWrite/PCWrite suppressed during the wait).
    typedef struct packed {
        ctl_t c;
        logic waits;
    } phase_t;

    phase_t plan[$];
    int     n_chk  = 0;
    int     n_fail = 0;
    int     n_ins  = 0;
    int     instr_m = 0;
    int     stall_m = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ctl_t dut_ctl();
        return {IRWrite, PCWrite, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc,
                ResultSrc, RegWrite, MemWrite, FlagWrite, illegal};
    endfunction

    // ARM encodes conditions as pairs: cond[3:1] picks a test, cond[0]
    // inverts it. AL inverted is 1111, which therefore never executes.
    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] fl);
        bit n, z, cy, v, base;
        {n, z, cy, v} = fl;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic void build_plan(input logic [1:0] o, input logic [5:0] f,
                                       input logic [3:0] c, input logic [3:0] fl);
        phase_t p;
        plan.delete();
        p = '0;
        p.c.ir = 1'b1; p.c.pcw = 1'b1; p.c.srca = 1'b1; p.c.srcb = 2'b10;
        p.c.aluop = 4'b0100; p.c.res = 2'b10; p.waits = 1'b1;
        plan.push_back(p);
        p = '0;
        p.c.ill = (o == 2'b11);
        plan.push_back(p);
        if (o == 2'b11 || !cond_holds(c, fl)) return;
        if (o == 2'b00) begin
            p = '0;
            p.c.srcb = f[5] ? 2'b01 : 2'b00;
            p.c.aluop = f[4:1];
            plan.push_back(p);
            p = '0;
            p.c.fw = f[0];
            p.c.rw = (f[4:1] != 4'b1010);
            plan.push_back(p);
        end else if (o == 2'b01) begin
            p = '0;
            p.c.srcb = 2'b01; p.c.imm = 2'b01;
            p.c.aluop = f[3] ? 4'b0100 : 4'b0010;
            plan.push_back(p);
            p = '0;
            p.c.adr = 1'b1; p.waits = 1'b1;
            if (f[0]) begin
                plan.push_back(p);
                p = '0;
                p.c.res = 2'b01; p.c.rw = 1'b1;
                plan.push_back(p);
            end else begin
                p.c.mw = 1'b1;
                plan.push_back(p);
            end
        end else begin
            p = '0;
            p.c.srca = 1'b1; p.c.srcb = 2'b01; p.c.imm = 2'b10;
            p.c.aluop = 4'b0100; p.c.res = 2'b10; p.c.pcw = 1'b1;
            plan.push_back(p);
        end
    endfunction

    function automatic int rand_wait();
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
    endfunction

    // Called just after a rising edge. fw/mw: wait cycles in FETCH and in the
    // memory step (-1 = random). rst_mid asserts reset after the MEMWR waits.
    task automatic run_instr(input logic [1:0] o, input logic [5:0] f, input logic [3:0] c,
                             input logic [3:0] fl, input int fw, input int mw, input bit rst_mid);
        ctl_t e;
        int   nw;
        build_plan(o, f, c, fl);
        op = o; funct = f; cond = c; NZCV = fl;
        n_ins++;
        for (int i = 0; i < plan.size(); i++) begin
            if (!plan[i].waits)  nw = 0;
            else if (i == 0)     nw = (fw < 0) ? rand_wait() : fw;
            else                 nw = (mw < 0) ? rand_wait() : mw;
            for (int k = 0; k <= nw; k++) begin
                e = plan[i].c;
                if (plan[i].waits && k < nw) begin
                    mem_ready = 1'b0;
                    e.ir = 1'b0; e.pcw = 1'b0;
                    stall_m++;
                end else if (plan[i].waits && rst_mid && plan[i].c.mw) begin
                    mem_ready = 1'b0;
                    reset = 1'b1;
                    @(negedge clk);
                    check_eq($sformatf("i%0d_rst", n_ins), 32'(dut_ctl()), 32'd0);
                    @(posedge clk); #1;
                    reset = 1'b0;
                    instr_m = 0; stall_m = 0;
                    @(negedge clk);
                    e = plan[0].c;
                    e.ir = 1'b0; e.pcw = 1'b0;
                    check_eq($sformatf("i%0d_postrst", n_ins), 32'(dut_ctl()), 32'(e));
`ifdef ARM_CTRL_PERF_EN
                    check_eq("cnt_clr_i", instr_cnt, 32'd0);
                    check_eq("cnt_clr_s", stall_cnt, 32'd0);
`endif
                    stall_m++;
                    @(posedge clk); #1;
                    return;
                end else if (plan[i].waits) begin
                    mem_ready = 1'b1;
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                check_eq($sformatf("i%0d_p%0d_w%0d", n_ins, i, k), 32'(dut_ctl()), 32'(e));
                @(posedge clk); #1;
            end
        end
        instr_m++;
`ifdef ARM_CTRL_PERF_EN
        check_eq($sformatf("i%0d_icnt", n_ins), instr_cnt, 32'(instr_m));
        check_eq($sformatf("i%0d_scnt", n_ins), stall_cnt, 32'(stall_m));
`endif
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1;
        op = 2'b11; funct = '1; cond = 4'b1110; NZCV = '0;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            check_eq("reset_ctl", 32'(dut_ctl()), 32'd0);
            @(posedge clk); #1;
        end
        reset = 1'b0;
`ifdef ARM_CTRL_PERF_EN
        check_eq("reset_icnt", instr_cnt, 32'd0);
        check_eq("reset_scnt", stall_cnt, 32'd0);
`endif
        // ADD r1,r2,#5
        run_instr(2'b00, 6'b101000, 4'b1110, 4'b0000, 0, 0, 1'b0);
        // CMP r1,r2
        run_instr(2'b00, 6'b010101, 4'b1110, 4'b0000, 0, 0, 1'b0);
        // BEQ, Z=0 then Z=1
        run_instr(2'b10, 6'b000000, 4'b0000, 4'b0000, 0, 0, 1'b0);
        run_instr(2'b10, 6'b000000, 4'b0000, 4'b0100, 0, 0, 1'b0);
        // LDR with two MEMRD wait cycles
        run_instr(2'b01, 6'b011001, 4'b1110, 4'b0000, 0, 2, 1'b0);
        // STR with waits, then STR aborted by reset in MEMWR
        run_instr(2'b01, 6'b011000, 4'b1110, 4'b0000, 1, 3, 1'b0);
        run_instr(2'b01, 6'b010000, 4'b1110, 4'b0000, 0, 2, 1'b1);
        // illegal op
        run_instr(2'b11, 6'b000000, 4'b1110, 4'b0000, 0, 0, 1'b0);
        // GE N=1 V=1, LT N=1 V=0, GT Z=1, NV
        run_instr(2'b00, 6'b001000, 4'b1010, 4'b1001, 0, 0, 1'b0);
        run_instr(2'b00, 6'b001000, 4'b1011, 4'b1000, 0, 0, 1'b0);
        run_instr(2'b00, 6'b001000, 4'b1100, 4'b0100, 0, 0, 1'b0);
        run_instr(2'b00, 6'b001000, 4'b1111, 4'b0000, 0, 0, 1'b0);
        // Random instructions and wait patterns
        for (int n = 0; n < 300; n++) begin
            run_instr(2'($urandom_range(0, 3)), 6'($urandom), 4'($urandom),
                      4'($urandom), -1, -1, ($urandom_range(0, 19) == 0));
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
